// File: rtl/alu16_pkg.sv
// Shared types and widths for the alu16 scheduler slice.
package alu16_pkg;

  localparam int ALU_W              = 16;
  localparam int ALU_OUT_W          = 17;
  localparam int ALU_OP_W           = 3;
  localparam int ALU_CYCLES_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    any       = |req;
    // Walk from the farthest offset back to ptr so the nearest requester is written last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu16_sched.sv
// Round-robin scheduler sharing one multi-cycle alu16 among NREQ requesters.
// One operation in flight: accept, start pulse, fixed-latency wait, one-cycle response.
module alu16_sched
  import alu16_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ALU_CYCLES = ALU_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ALU_W-1:0]    req_a,
  input  logic [NREQ*ALU_W-1:0]    req_b,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
  output logic [NREQ-1:0]          resp_valid,
  output logic [ALU_OUT_W-1:0]     resp_data,
  output logic                     busy,
  output logic [ALU_W-1:0]         alu_ina,
  output logic [ALU_W-1:0]         alu_inb,
  output logic [ALU_OP_W-1:0]      alu_op,
  output logic                     alu_on,
  input  logic [ALU_OUT_W-1:0]     alu_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ALU_CYCLES + 1);

  state_e          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] gnt_q;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  logic [NREQ-1:0]     arb_req;
  logic [NREQ-1:0]     arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [ALU_W-1:0]    sel_a, sel_b;
  logic [ALU_OP_W-1:0] sel_op;

  // Masking with rst_n keeps req_ready low for as long as reset is held.
  assign arb_req  = req_valid & {NREQ{rst_n}};
  assign cnt_last = (cnt == CW'(ALU_CYCLES - 1));

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // One-hot AND-OR select of the granted requester's operands.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_a  = req_a[i*ALU_W +: ALU_W];
        sel_b  = req_b[i*ALU_W +: ALU_W];
        sel_op = req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gnt_q     <= '0;
      cnt       <= '0;
      alu_ina   <= '0;
      alu_inb   <= '0;
      alu_op    <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (arb_any) begin
          gidx    <= arb_idx;
          gnt_q   <= arb_grant;
          alu_ina <= sel_a;
          alu_inb <= sel_b;
          alu_op  <= sel_op;
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) resp_data <= alu_out;
        end
        DONE: ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    alu_on     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (arb_any) begin
        req_ready = arb_grant;
        state_nxt = START;
      end
      START: begin
        alu_on    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt_last) state_nxt = DONE;
      DONE: begin
        resp_valid = gnt_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
